// File: rtl/mcp9808_multi_poller.sv
// I2C master polling the ambient-temperature register (0x05) of up to N_CH MCP9808 sensors
// on one open-drain bus, one read transaction per channel, in one-shot or free-running sweeps.
module mcp9808_multi_poller #(
   parameter int          N_CH      = 4,
   parameter int          QDIV      = 125,
   parameter logic [23:0] ADDR_PINS = 24'o76543210,
   parameter logic [15:0] AUTO_GAP  = 16'd1000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               scl_i,
   output logic               scl_oe,
   input  logic               sda_i,
   output logic               sda_oe,
   input  logic               start,
   input  logic               auto_en,
   output logic               busy,
   output logic               done,
   output logic [13*N_CH-1:0] temp_o,
   output logic [N_CH-1:0]    valid_o,
   output logic [N_CH-1:0]    nack_o
);
   localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int QW = $clog2(QDIV);

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_TXBYTE, S_TXACK, S_RSTART, S_RXBYTE,
      S_MACK, S_MNACK, S_STOP, S_NEXT, S_GAP
   } state_t;

   state_t          state;
   logic [QW-1:0]   qcnt;
   logic [1:0]      phase;
   logic [2:0]      bit_cnt;
   logic [1:0]      byte_idx;
   logic            rx_lsb;
   logic            nak;
   logic [CW-1:0]   ch;
   logic [7:0]      tx_sr;
   logic [6:0]      rx_sr;
   logic [4:0]      msb;
   logic [15:0]     gap_cnt;
   logic [2:0]      pins;
   logic            stretch;
   logic            tick;
   logic            sample;
   logic            bit_end;

   assign pins    = ADDR_PINS[3*int'(ch) +: 3];
   assign stretch = ~scl_oe & ~scl_i;
   assign tick    = (qcnt == QW'(QDIV - 1)) && !stretch;
   assign sample  = tick && (phase == 2'd2);
   assign bit_end = tick && (phase == 2'd3);

   // Bus drive {scl_oe, sda_oe} for a given quarter; in quarter 0 SDA holds its previous level
   // so it only ever moves while SCL is already low.
   function automatic logic [1:0] line_drive(state_t st, logic [1:0] ph, logic tx_bit,
                                             logic sda_hold);
      case (st)
         S_START:  return {ph == 2'd3, ph != 2'd0};
         S_RSTART: return {(ph == 2'd0) || (ph == 2'd3), ph[1]};
         S_STOP:   return {!ph[1], (ph == 2'd1) || (ph == 2'd2)};
         S_TXBYTE: return {!ph[1], (ph == 2'd0) ? sda_hold : ~tx_bit};
         S_MACK:   return {!ph[1], (ph == 2'd0) ? sda_hold : 1'b1};
         S_TXACK, S_RXBYTE, S_MNACK:
                   return {!ph[1], (ph == 2'd0) && sda_hold};
         default:  return 2'b00;
      endcase
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: reset drops both line drivers at once; a transfer cut short gets no STOP.
      if (rst) begin
         state    <= S_IDLE;
         qcnt     <= '0;
         phase    <= '0;
         bit_cnt  <= '0;
         byte_idx <= '0;
         rx_lsb   <= 1'b0;
         nak      <= 1'b0;
         ch       <= '0;
         tx_sr    <= '0;
         rx_sr    <= '0;
         msb      <= '0;
         gap_cnt  <= '0;
         scl_oe   <= 1'b0;
         sda_oe   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         temp_o   <= '0;
         valid_o  <= '0;
         nack_o   <= '0;
      end else begin
         done <= 1'b0;
         {scl_oe, sda_oe} <= line_drive(state, phase, tx_sr[7], sda_oe);

         if (state == S_IDLE || state == S_NEXT || tick) qcnt <= '0;
         else if (!stretch)                              qcnt <= qcnt + 1'b1;

         if (tick && state != S_GAP) phase <= phase + 2'd1;

         case (state)
            S_IDLE: begin
               if (start || auto_en) begin
                  state <= S_START;
                  busy  <= 1'b1;
               end
            end
            S_START: begin
               if (bit_end) begin
                  state    <= S_TXBYTE;
                  tx_sr    <= {4'b0011, pins, 1'b0};
                  byte_idx <= 2'd0;
                  bit_cnt  <= 3'd0;
               end
            end
            S_TXBYTE: begin
               if (bit_end) begin
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) state <= S_TXACK;
                  else                 tx_sr <= {tx_sr[6:0], 1'b0};
               end
            end
            S_TXACK: begin
               if (sample) begin
                  nak <= sda_i;
                  if (sda_i) begin
                     nack_o[ch]  <= 1'b1;
                     valid_o[ch] <= 1'b0;
                  end
               end
               if (bit_end) begin
                  if (nak) state <= S_STOP;
                  else begin
                     case (byte_idx)
                        2'd0: begin
                           state    <= S_TXBYTE;
                           tx_sr    <= 8'h05;
                           byte_idx <= 2'd1;
                        end
                        2'd1:    state <= S_RSTART;
                        default: begin
                           state  <= S_RXBYTE;
                           rx_lsb <= 1'b0;
                        end
                     endcase
                  end
               end
            end
            S_RSTART: begin
               if (bit_end) begin
                  state    <= S_TXBYTE;
                  tx_sr    <= {4'b0011, pins, 1'b1};
                  byte_idx <= 2'd2;
                  bit_cnt  <= 3'd0;
               end
            end
            S_RXBYTE: begin
               if (sample) begin
                  rx_sr <= {rx_sr[5:0], sda_i};
                  if (bit_cnt == 3'd7) begin
                     if (rx_lsb) begin
                        temp_o[13*int'(ch) +: 13] <= {msb, rx_sr, sda_i};
                        valid_o[ch]               <= 1'b1;
                        nack_o[ch]                <= 1'b0;
                     end else begin
                        msb <= {rx_sr[3:0], sda_i};
                     end
                  end
               end
               if (bit_end) begin
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) state <= rx_lsb ? S_MNACK : S_MACK;
               end
            end
            S_MACK: begin
               if (bit_end) begin
                  state  <= S_RXBYTE;
                  rx_lsb <= 1'b1;
               end
            end
            S_MNACK: if (bit_end) state <= S_STOP;
            S_STOP:  if (bit_end) state <= S_NEXT;
            S_NEXT: begin
               if (ch == CW'(N_CH - 1)) begin
                  ch      <= '0;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  gap_cnt <= '0;
                  state   <= auto_en ? S_GAP : S_IDLE;
               end else begin
                  ch    <= ch + 1'b1;
                  state <= S_START;
               end
            end
            S_GAP: begin
               if (!auto_en) state <= S_IDLE;
               else if (tick) begin
                  if (({1'b0, gap_cnt} + 17'd1) >= {1'b0, AUTO_GAP}) begin
                     state   <= S_START;
                     busy    <= 1'b1;
                     gap_cnt <= '0;
                  end else begin
                     gap_cnt <= gap_cnt + 16'd1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mcp9808_multi_poller.sv
// Directed bench: two MCP9808 slave models on a shared open-drain bus, with NACK,
// clock-stretch, auto-sweep and mid-transfer reset scenarios.
module tb_mcp9808_multi_poller;
   localparam int M_ADDR = 0, M_PTR = 1, M_READ = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        auto_en = 1'b0;
   logic        scl_oe, sda_oe, busy, done;
   logic [25:0] temp_o;
   logic [1:0]  valid_o, nack_o;
   wire         scl_line, sda_line;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] msb_tab [2];
   logic [7:0] lsb_tab [2];
   logic [1:0] ack_en = 2'b11;
   int         stretch_req = 0;

   // Slave model state, owned by the single slave process below.
   logic       s_drive = 1'b0, scl_hold = 1'b0, scl_q = 1'b1, sda_q = 1'b1;
   logic       s_active = 1'b0, s_post_ack = 1'b0, s_rw = 1'b0, s_mack = 1'b0, s_sel = 1'b0;
   logic       cur_scl, cur_sda;
   int         s_bit = 0, s_mode = 0, s_rd = 0, stretch_left = 0, stretch_ack = 0;
   int         n_start = 0, n_stop = 0;
   logic [7:0] s_sr = 8'h00, s_tx = 8'h00;

   assign scl_line = ~(scl_oe | scl_hold);
   assign sda_line = ~(sda_oe | s_drive);

   mcp9808_multi_poller #(
      .N_CH(2), .QDIV(4), .ADDR_PINS(24'o76543210), .AUTO_GAP(16'd10)
   ) dut (
      .clk(clk), .rst(rst), .scl_i(scl_line), .scl_oe(scl_oe), .sda_i(sda_line),
      .sda_oe(sda_oe), .start(start), .auto_en(auto_en), .busy(busy), .done(done),
      .temp_o(temp_o), .valid_o(valid_o), .nack_o(nack_o)
   );

   always #5 clk = ~clk;

   // Sensor model: polls the bus mid-cycle, addresses 0x18 (ch0) and 0x19 (ch1).
   always @(negedge clk) begin
      if (rst) begin
         s_drive = 1'b0; scl_hold = 1'b0; scl_q = 1'b1; sda_q = 1'b1;
         s_active = 1'b0; s_post_ack = 1'b0; s_bit = 0; s_mode = M_ADDR; stretch_left = 0;
      end else begin
         cur_scl = !(scl_oe || scl_hold);
         cur_sda = !(sda_oe || s_drive);
         if (scl_q && cur_scl && sda_q && !cur_sda) begin
            n_start++; s_active = 1'b1; s_bit = 0; s_mode = M_ADDR; s_post_ack = 1'b0;
            s_drive = 1'b0;
         end else if (scl_q && cur_scl && !sda_q && cur_sda) begin
            n_stop++; s_active = 1'b0; s_drive = 1'b0;
         end else if (!scl_q && cur_scl) begin
            if (s_active) begin
               if (s_bit < 8) s_sr = {s_sr[6:0], cur_sda};
               else           s_mack = !cur_sda;
               s_bit = (s_bit == 8) ? 0 : s_bit + 1;
            end
         end else if (scl_q && !cur_scl && s_active) begin
            if (s_bit == 8) begin
               s_post_ack = 1'b1;
               if (s_mode == M_READ) s_drive = 1'b0;
               else if (s_mode == M_ADDR && s_sr[7:2] == 6'b001100 && ack_en[s_sr[1]]) begin
                  s_sel = s_sr[1]; s_rw = s_sr[0]; s_drive = 1'b1;
               end else if (s_mode == M_PTR && s_sr == 8'h05) s_drive = 1'b1;
               else begin
                  s_active = 1'b0; s_drive = 1'b0;
               end
            end else if (s_bit == 0) begin
               if (s_post_ack) begin
                  s_post_ack = 1'b0;
                  if (s_mode == M_ADDR && s_rw) begin
                     s_mode = M_READ; s_rd = 0; s_tx = msb_tab[s_sel]; s_drive = !s_tx[7];
                  end else if (s_mode == M_ADDR) begin
                     s_mode = M_PTR; s_drive = 1'b0;
                  end else if (s_mode == M_PTR) begin
                     s_drive = 1'b0;
                     if (stretch_req != stretch_ack) begin
                        stretch_ack = stretch_req; scl_hold = 1'b1; stretch_left = 50;
                     end
                  end else if (s_mack && s_rd == 0) begin
                     s_rd = 1; s_tx = lsb_tab[s_sel]; s_drive = !s_tx[7];
                  end else begin
                     s_drive = 1'b0; s_active = 1'b0;
                  end
               end else s_drive = 1'b0;
            end else if (s_mode == M_READ) s_drive = !s_tx[7-s_bit];
            else s_drive = 1'b0;
         end
         scl_q = !(scl_oe || scl_hold);
         sda_q = !(sda_oe || s_drive);
         if (stretch_left > 0) begin
            stretch_left--;
            if (stretch_left == 0) scl_hold = 1'b0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   // One start-triggered sweep; a stray start mid-sweep must be ignored.
   task automatic run_sweep(output int cyc, output int dones);
      int n;
      dones = 0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      check("busy_after_start", busy, 1);
      n = 0;
      while (busy && n < 6000) begin
         start = (n == 300);
         @(negedge clk);
         n++;
         if (done) dones++;
      end
      start = 1'b0;
      check("sweep_in_budget", n < 6000, 1);
      repeat (20) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("busy_stays_low", busy, 0);
      cyc = n;
   endtask

   initial begin
      int cyc1, cyc3, dones, st0, sp0, n, last_done, gap, min_gap;
      logic prev_busy;
      msb_tab[0] = 8'hC1; lsb_tab[0] = 8'h94;
      msb_tab[1] = 8'h1F; lsb_tab[1] = 8'hF0;

      repeat (4) @(negedge clk);
      check("rst_scl_oe", scl_oe, 0);
      check("rst_sda_oe", sda_oe, 0);
      check("rst_busy_done", {busy, done}, 0);
      check("rst_temp", temp_o, 0);
      check("rst_valid_nack", {valid_o, nack_o}, 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("idle_bus_released", {scl_oe, sda_oe, busy}, 0);

      // Sweep 1: both sensors answer.
      st0 = n_start; sp0 = n_stop;
      run_sweep(cyc1, dones);
      check("s1_done_once", dones, 1);
      check("s1_temp_ch0", temp_o[12:0], 13'h0194);
      check("s1_temp_ch1", temp_o[25:13], 13'h1FF0);
      check("s1_valid", valid_o, 2'b11);
      check("s1_nack", nack_o, 2'b00);
      check("s1_starts", n_start - st0, 4);
      check("s1_stops", n_stop - sp0, 2);

      // Sweep 2: ch1 ignores its address, ch0 reports a new reading.
      ack_en = 2'b01; msb_tab[0] = 8'h01; lsb_tab[0] = 8'h50;
      st0 = n_start; sp0 = n_stop;
      run_sweep(cyc3, dones);
      check("s2_done_once", dones, 1);
      check("s2_temp_ch0", temp_o[12:0], 13'h0150);
      check("s2_temp_ch1_held", temp_o[25:13], 13'h1FF0);
      check("s2_valid", valid_o, 2'b01);
      check("s2_nack", nack_o, 2'b10);
      check("s2_starts", n_start - st0, 3);
      check("s2_stops", n_stop - sp0, 2);

      // Sweep 3: ch0 stretches SCL for ~50 clk after the pointer ack.
      ack_en = 2'b11; msb_tab[0] = 8'hC1; lsb_tab[0] = 8'h94;
      stretch_req = 1;
      run_sweep(cyc3, dones);
      check("s3_stretch_used", stretch_ack, 1);
      check("s3_temp_ch0", temp_o[12:0], 13'h0194);
      check("s3_valid_nack", {valid_o, nack_o}, 4'b1100);
      // 50 held clk minus the quarters already elapsed before the release window: 40..50.
      check("s3_stretch_delay", (cyc3 - cyc1 >= 40) && (cyc3 - cyc1 <= 50), 1);

      // Auto mode: three sweeps, auto_en dropped once the third has begun.
      @(negedge clk); auto_en = 1'b1;
      dones = 0; last_done = -1; min_gap = 1000000; prev_busy = busy; n = 0;
      while (n < 20000 && !(dones == 3 && !busy)) begin
         @(negedge clk);
         n++;
         if (done) begin
            dones++;
            last_done = n;
         end
         if (busy && !prev_busy && last_done >= 0) begin
            gap = n - last_done;
            if (gap < min_gap) min_gap = gap;
            if (dones == 2) auto_en = 1'b0;
         end
         prev_busy = busy;
      end
      auto_en = 1'b0;
      check("auto_in_budget", n < 20000, 1);
      check("auto_three_dones", dones, 3);
      check("auto_gap_min", min_gap >= 40, 1);
      repeat (200) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("auto_then_idle", {busy, 2'(dones)}, {1'b0, 2'd3});
      check("auto_valid", valid_o, 2'b11);

      // Reset in the middle of a read byte, then a clean sweep.
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      n = 0;
      while (!(s_active && s_mode == M_READ) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("reach_read_phase", n < 3000, 1);
      repeat (30) @(negedge clk);
      check("busy_before_rst", busy, 1);
      @(posedge clk); #2 rst = 1'b1;
      #1;
      check("midrst_lines", {scl_oe, sda_oe}, 2'b00);
      check("midrst_busy_done", {busy, done}, 0);
      check("midrst_temp", temp_o, 0);
      check("midrst_valid_nack", {valid_o, nack_o}, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      run_sweep(cyc1, dones);
      check("post_rst_done", dones, 1);
      check("post_rst_temp", temp_o, {13'h1FF0, 13'h0194});
      check("post_rst_valid", valid_o, 2'b11);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
